voice_mixer: RTL and testbench
==============================

// Module: voice_mixer
// PURPOSE
//   Parametrised, time-multiplexed N-voice mixer. Replaces the fixed 4-voice osc_sum adder in synth.
//   Per sample_tick it snapshots all voice samples, gains and enables, then MACs one voice per Clk.
//   It scales, saturates and presents one signed sample to audio_interface LDATA/RDATA.
//   Adds per-voice gain, voice enable, saturation with clip flag and overrun detection.
// PARAMETERS
//   NUM_VOICES  8   voices mixed, >=2
//   SAMPLE_W    16  signed two's-complement sample width, in and out
//   GAIN_W      8   unsigned gain width, Q1.(GAIN_W-1): 2^(GAIN_W-1) = unity (128 at default)
//   SHIFT       3   arithmetic right shift applied to the accumulated sum (headroom)
// PORTS
//   Clk         in   1                    system clock (CLOCK_50)
//   Reset_n     in   1                    async active-low reset
//   sample_tick in   1                    1-Clk pulse per audio sample, already in Clk domain
//   voice_in    in   NUM_VOICES*SAMPLE_W  packed signed samples, voice k at [k*SAMPLE_W +: SAMPLE_W]
//   voice_gain  in   NUM_VOICES*GAIN_W    packed unsigned gains, voice k at [k*GAIN_W +: GAIN_W]
//   voice_en    in   NUM_VOICES           1 = voice contributes to the mix
//   mix_out     out  SAMPLE_W             signed mixed sample, held between updates
//   mix_valid   out  1                    1-Clk pulse when mix_out updates
//   clip        out  1                    1-Clk pulse with mix_valid when saturation occurred
//   busy        out  1                    high while a mix is in progress
//   overrun     out  1                    1-Clk pulse when sample_tick arrives while busy
//   peak_level  out  SAMPLE_W             max |mix_out| since last clear (MIXER_PEAK_EN only)
//   peak_clr    in   1                    synchronous clear of peak_level
// BEHAVIOUR
//   Reset (async, Reset_n=0): all outputs 0, FSM=IDLE, accumulator 0, voice index 0, snapshots 0.
//   FSM: IDLE -> ACCUM -> DONE -> IDLE.
//   IDLE: on the edge sampling sample_tick=1: register voice_in, voice_gain and voice_en into snapshots.
//     Same edge: clear accumulator, idx=0, go to ACCUM. busy is high from the following cycle.
//   ACCUM: each edge adds term(idx) to acc and increments idx.
//     After idx=NUM_VOICES-1 is added, go to DONE, so ACCUM lasts exactly NUM_VOICES cycles.
//   term(k) = en[k] ? (s[k] * $signed({1'b0,g[k]})) >>> (GAIN_W-1) : 0.
//     Product width is SAMPLE_W+GAIN_W+1 signed; the shift truncates toward -inf.
//   Accumulator width is SAMPLE_W+GAIN_W+1+$clog2(NUM_VOICES) signed and can never overflow.
//   DONE edge: r = acc >>> SHIFT, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
//     mix_out <= r; mix_valid <= 1; clip <= (r was out of range); go to IDLE.
//     busy drops in the cycle mix_valid is high.
//   Latency: mix_valid is high NUM_VOICES+2 cycles after the cycle in which sample_tick was high.
//   Input changes after the tick edge do not affect the current mix; snapshots are used throughout.
//   sample_tick while not IDLE: the tick is dropped, overrun pulses 1 cycle, the current mix is unaffected.
//   Tick on the same cycle as mix_valid is accepted, because the FSM is already IDLE.
//   Back-to-back mixes are spaced at NUM_VOICES+2 cycles minimum.
//   mix_valid, clip and overrun are single-cycle pulses. mix_out holds its value until the next DONE.
//   Reset mid-operation aborts the mix with no mix_valid. The next tick after release behaves normally.
// CONFIGURATION
//   MIXER_PEAK_EN defined:
//     On each mix_valid, peak_level <= max(peak_level, |mix_out_new|); |-2^(SAMPLE_W-1)| saturates to 2^(SAMPLE_W-1)-1.
//     peak_clr=1 clears to 0. If peak_clr and mix_valid coincide, peak_level takes |mix_out_new| (clear wins, then update).
//   MIXER_PEAK_EN undefined: peak_level tied to 0, peak_clr ignored, no peak logic synthesised.
// TESTING (defaults NUM_VOICES=8, SAMPLE_W=16, GAIN_W=8, SHIFT=3)
//   1. All voices 0x1000, gain 128, en=0xFF, one tick.
//      -> mix_out=0x1000, clip=0, mix_valid exactly 10 cycles after the tick cycle.
//   2. All voices 0x7FFF, gain 255, en=0xFF -> mix_out=0x7FFF, clip=1.
//      Then all voices 0x8000, gain 255 -> mix_out=0x8000, clip=1.
//   3. en=0x01, voice0=0x0800 gain 64, others 0x7FFF gain 255 -> mix_out=0x0080, clip=0.
//   4. Tick, then change voice_in and voice_en on the next cycle.
//      -> result equals the pre-change mix. A second tick 3 cycles later gives overrun=1 and only one mix_valid.
//   5. Assert Reset_n=0 during ACCUM (idx=4) -> all outputs 0 immediately, no mix_valid.
//      Release and run test 1 -> 0x1000.
//   6. MIXER_PEAK_EN: mixes giving 0x0400, then 0xF000 (-4096), then 0x0100 -> peak_level=0x1000.
//      peak_clr -> 0. Build without the macro -> peak_level stays 0.

Source files
------------

// File: rtl/voice_mixer.sv
// Time-multiplexed N-voice mixer. Snapshots voices on sample_tick, then MACs one voice per clock.
// Optional peak meter built only when MIXER_PEAK_EN is defined.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8,
    parameter int SHIFT      = 3
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [NUM_VOICES-1:0]          voice_en,
    output logic [SAMPLE_W-1:0]            mix_out,
    output logic                           mix_valid,
    output logic                           clip,
    output logic                           busy,
    output logic                           overrun,
    output logic [SAMPLE_W-1:0]            peak_level,
    input  logic                           peak_clr
);
    // state | meaning
    // IDLE  | waiting for sample_tick; snapshot taken on the accepting edge
    // ACCUM | adds one gained voice per clock, NUM_VOICES cycles
    // DONE  | shift, saturate and publish the mix
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
    localparam int IDX_W  = $clog2(NUM_VOICES);

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (SAMPLE_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    state_t state, state_nxt;

    logic signed [SAMPLE_W-1:0] snap_s [NUM_VOICES];
    logic        [GAIN_W-1:0]   snap_g [NUM_VOICES];
    logic        [NUM_VOICES-1:0] snap_en;
    logic signed [ACC_W-1:0]    acc;
    logic        [IDX_W-1:0]    idx;
    logic                       last_voice;

    logic signed [PROD_W-1:0]   samp_ext, gain_ext, prod, term;
    logic signed [ACC_W-1:0]    term_ext, sum_sh;
    logic signed [SAMPLE_W-1:0] sat_val;
    logic                       sat_hit;

    assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_tick) state_nxt = ACCUM;
            ACCUM:   if (last_voice)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gain is Q1.(GAIN_W-1); the shift floors toward -inf.
    always_comb begin
        samp_ext = PROD_W'(snap_s[idx]);
        gain_ext = PROD_W'($signed({1'b0, snap_g[idx]}));
        prod     = samp_ext * gain_ext;
        term     = prod >>> (GAIN_W - 1);
        term_ext = snap_en[idx] ? ACC_W'(term) : '0;
    end

    always_comb begin
        sum_sh  = acc >>> SHIFT;
        sat_hit = 1'b1;
        if (sum_sh > SAT_MAX)      sat_val = SAT_MAX[SAMPLE_W-1:0];
        else if (sum_sh < SAT_MIN) sat_val = SAT_MIN[SAMPLE_W-1:0];
        else begin
            sat_val = sum_sh[SAMPLE_W-1:0];
            sat_hit = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                snap_s[k] <= '0;
                snap_g[k] <= '0;
            end
            snap_en   <= '0;
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= sample_tick && (state != IDLE);
            case (state)
                IDLE: if (sample_tick) begin
                    for (int k = 0; k < NUM_VOICES; k++) begin
                        snap_s[k] <= voice_in[k*SAMPLE_W +: SAMPLE_W];
                        snap_g[k] <= voice_gain[k*GAIN_W +: GAIN_W];
                    end
                    snap_en <= voice_en;
                    acc     <= '0;
                    idx     <= '0;
                end
                ACCUM: begin
                    acc <= acc + term_ext;
                    idx <= last_voice ? '0 : idx + IDX_W'(1);
                end
                DONE: begin
                    mix_out   <= sat_val;
                    mix_valid <= 1'b1;
                    clip      <= sat_hit;
                end
                default: ;
            endcase
        end
    end

`ifdef MIXER_PEAK_EN
    logic [SAMPLE_W-1:0] abs_new;

    // The most negative code has no positive twin, so it reads as full scale.
    always_comb begin
        if (sat_val == SAT_MIN[SAMPLE_W-1:0]) abs_new = SAT_MAX[SAMPLE_W-1:0];
        else if (sat_val[SAMPLE_W-1])         abs_new = SAMPLE_W'(-sat_val);
        else                                  abs_new = sat_val;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            peak_level <= '0;
        end else if (state == DONE) begin
            if (peak_clr || (abs_new > peak_level)) peak_level <= abs_new;
        end else if (peak_clr) begin
            peak_level <= '0;
        end
    end
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_level      = '0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed cases plus randomized mixes against an arithmetic model.
module tb_voice_mixer;
    localparam int NV = 8;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           sample_tick;
    logic [NV*16-1:0] voice_in;
    logic [NV*8-1:0]  voice_gain;
    logic [NV-1:0]    voice_en;
    logic [15:0]    mix_out;
    logic           mix_valid;
    logic           clip;
    logic           busy;
    logic           overrun;
    logic [15:0]    peak_level;
    logic           peak_clr;

    logic signed [15:0] vs [NV];
    logic        [7:0]  vg [NV];

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_peak = '0;

    voice_mixer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .sample_tick(sample_tick),
        .voice_in   (voice_in),
        .voice_gain (voice_gain),
        .voice_en   (voice_en),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .clip       (clip),
        .busy       (busy),
        .overrun    (overrun),
        .peak_level (peak_level),
        .peak_clr   (peak_clr)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        voice_in   = '0;
        voice_gain = '0;
        for (int k = 0; k < NV; k++) begin
            voice_in[k*16 +: 16] = vs[k];
            voice_gain[k*8 +: 8] = vg[k];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: sum of floor(s*g/128) over enabled voices, floor-divide by 8, clamp.
    task automatic model(output logic [15:0] r, output logic c);
        longint acc, p, s;
        acc = 0;
        for (int k = 0; k < NV; k++) begin
            if (voice_en[k]) begin
                p   = longint'(vs[k]) * longint'({24'd0, vg[k]});
                acc = acc + (p >>> 7);
            end
        end
        s = acc >>> 3;
        c = 1'b1;
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else begin
            r = s[15:0];
            c = 1'b0;
        end
    endtask

    task automatic set_all(input logic [15:0] s, input logic [7:0] g, input logic [NV-1:0] en);
        for (int k = 0; k < NV; k++) begin
            vs[k] = s;
            vg[k] = g;
        end
        voice_en = en;
    endtask

    task automatic peak_track(input logic [15:0] r);
`ifdef MIXER_PEAK_EN
        logic [15:0] a;
        if (r == 16'h8000)  a = 16'h7FFF;
        else if (r[15])     a = -r;
        else                a = r;
        if (a > exp_peak) exp_peak = a;
`else
        if (r === 16'hxxxx) exp_peak = 16'h0;
`endif
    endtask

    // One tick and its mix; with perturb, inputs change after the tick and a second tick lands mid-mix.
    task automatic run_mix(input string tag, input logic [15:0] exp_out, input logic exp_clip,
                           input bit perturb);
        int   cnt;
        bit   busy_bad, ovr_seen, extra_valid;
        logic [15:0] held;
        busy_bad = 0;
        ovr_seen = 0;
        extra_valid = 0;
        @(negedge Clk);
        sample_tick = 1'b1;
        @(negedge Clk);
        sample_tick = 1'b0;
        cnt = 1;
        if (perturb) begin
            for (int k = 0; k < NV; k++) vs[k] = 16'($urandom);
            voice_en = 8'($urandom);
        end
        while (!mix_valid && cnt < 20) begin
            if (!busy) busy_bad = 1;
            if (perturb && cnt == 3) sample_tick = 1'b1;
            if (perturb && cnt == 4) begin
                sample_tick = 1'b0;
                check({tag, "_overrun"}, 32'(overrun), 32'd1);
            end else if (overrun) begin
                ovr_seen = 1;
            end
            @(negedge Clk);
            cnt++;
        end
        peak_track(exp_out);
        check({tag, "_latency"}, 32'(cnt), 32'd10);
        check({tag, "_mix_out"}, 32'(mix_out), 32'(exp_out));
        check({tag, "_clip"}, 32'(clip), 32'(exp_clip));
        check({tag, "_busy"}, {30'd0, busy_bad, busy}, 32'd0);
        check({tag, "_stray_ovr"}, 32'(ovr_seen), 32'd0);
        check({tag, "_peak"}, 32'(peak_level), 32'(exp_peak));
        held = mix_out;
        @(negedge Clk);
        check({tag, "_pulse"}, {30'd0, mix_valid, clip}, 32'd0);
        check({tag, "_hold"}, 32'(mix_out), 32'(exp_out));
        if (perturb) begin
            for (int i = 0; i < 12; i++) begin
                if (mix_valid) extra_valid = 1;
                @(negedge Clk);
            end
            check({tag, "_single_valid"}, {31'd0, extra_valid}, 32'd0);
            check({tag, "_held_after"}, 32'(mix_out), 32'(held));
        end
    endtask

    initial begin
        logic [15:0] r;
        logic        c;
        Reset_n     = 1'b0;
        sample_tick = 1'b0;
        peak_clr    = 1'b0;
        set_all(16'h0, 8'h0, '0);
        repeat (3) @(negedge Clk);
        check("rst_outputs", {8'd0, mix_out, mix_valid, clip, busy, overrun, 4'd0}, 32'd0);
        check("rst_peak", 32'(peak_level), 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        set_all(16'h1000, 8'd128, 8'hFF);
        run_mix("t1_unity", 16'h1000, 1'b0, 0);

        set_all(16'h7FFF, 8'd255, 8'hFF);
        run_mix("t2_pos_sat", 16'h7FFF, 1'b1, 0);
        set_all(16'h8000, 8'd255, 8'hFF);
        run_mix("t2_neg_sat", 16'h8000, 1'b1, 0);

        set_all(16'h7FFF, 8'd255, 8'h01);
        vs[0] = 16'h0800;
        vg[0] = 8'd64;
        run_mix("t3_enable", 16'h0080, 1'b0, 0);

        for (int k = 0; k < NV; k++) begin
            vs[k] = 16'($urandom) >>> 2;
            vg[k] = 8'($urandom);
        end
        voice_en = 8'($urandom);
        model(r, c);
        run_mix("t4_snapshot", r, c, 1);

        set_all(16'h1000, 8'd128, 8'hFF);
        @(negedge Clk);
        sample_tick = 1'b1;
        @(negedge Clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("t5_reset_abort", {8'd0, mix_out, mix_valid, clip, busy, overrun, 4'd0}, 32'd0);
        exp_peak = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (mix_valid) seen = 1;
                @(negedge Clk);
            end
            check("t5_no_valid", {31'd0, seen}, 32'd0);
        end
        run_mix("t5_after_reset", 16'h1000, 1'b0, 0);

        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NV; k++) begin
                logic [15:0] t;
                t = 16'($urandom);
                vs[k] = (it % 2 == 0) ? t : {{3{t[15]}}, t[15:3]};
                vg[k] = 8'($urandom);
            end
            voice_en = 8'($urandom);
            model(r, c);
            run_mix("rand", r, c, 0);
        end

        @(negedge Clk);
        peak_clr = 1'b1;
        @(negedge Clk);
        peak_clr = 1'b0;
        exp_peak = '0;
        check("t6_clear_pre", 32'(peak_level), 32'd0);
        set_all(16'h0400, 8'd128, 8'hFF);
        run_mix("t6_a", 16'h0400, 1'b0, 0);
        set_all(16'hF000, 8'd128, 8'hFF);
        run_mix("t6_b", 16'hF000, 1'b0, 0);
        set_all(16'h0100, 8'd128, 8'hFF);
        run_mix("t6_c", 16'h0100, 1'b0, 0);
`ifdef MIXER_PEAK_EN
        check("t6_peak", 32'(peak_level), 32'h1000);
`else
        check("t6_peak_off", 32'(peak_level), 32'h0);
`endif
        @(negedge Clk);
        peak_clr = 1'b1;
        @(negedge Clk);
        peak_clr = 1'b0;
        exp_peak = '0;
        check("t6_clear", 32'(peak_level), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
